// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;
  localparam int AES_NR_128   = 10;
  localparam int SUBBYTES_LAT = 5;
  localparam int ROUND_W      = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    SUB  = 3'd2,
    ARK  = 3'd3,
    DONE = 3'd4
  } ctrl_state_e;
endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control bus between the AES wrapper (master) and the round sequencer (slave).
interface aes_round_ctrl_if;
  import aes_ctrl_pkg::*;

  logic               start;
  logic               key_valid;
  logic               busy;
  logic               done;
  logic [ROUND_W-1:0] round;
  logic               sub_en;
  logic               state_ld;
  logic               sel_init;
  logic               mix_bypass;
  logic               key_req;

  modport master (
    output start, key_valid,
    input  busy, done, round, sub_en, state_ld, sel_init, mix_bypass, key_req
  );

  modport slave (
    input  start, key_valid,
    output busy, done, round, sub_en, state_ld, sel_init, mix_bypass, key_req
  );
endinterface

// File: rtl/aes_round_ctrl_timer.sv
// SubBytes dwell timer: reloads while idle, flags expire on the CYCLES-th enabled cycle.
module aes_sub_timer #(
  parameter int CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= CW'(CYCLES - 1);
    else if (en && cnt != '0) cnt <= cnt - CW'(1);
  end

  assign expire = en && (cnt == '0);
endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 datapath.
// Define AES_CTRL_KEY_WAIT_EN to stall INIT/ARK until key_valid is high.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR         = AES_NR_128,
  parameter int SUB_CYCLES = SUBBYTES_LAT
) (
  input logic             clk,
  input logic             rst,
  aes_round_ctrl_if.slave ctrl
);
  if (NR < 1 || NR > 14) begin : g_nr_chk
    $error("aes_round_ctrl: NR must be in 1..14 to fit the round counter");
  end
  if (SUB_CYCLES < 1) begin : g_sub_chk
    $error("aes_round_ctrl: SUB_CYCLES must be at least 1");
  end

  ctrl_state_e        state, state_nxt;
  logic [ROUND_W-1:0] round_q;
  logic               key_ok, last_round, expire;

`ifdef AES_CTRL_KEY_WAIT_EN
  assign key_ok = ctrl.key_valid;
`else
  assign key_ok = 1'b1;
`endif

  assign last_round = (round_q == ROUND_W'(NR));

  // Timer reloads in every non-SUB state, so each round starts a fresh dwell.
  aes_sub_timer #(.CYCLES(SUB_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state != SUB),
    .en     (state == SUB),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ctrl.start) state_nxt = INIT;
      INIT:    if (key_ok)     state_nxt = SUB;
      SUB:     if (expire)     state_nxt = ARK;
      ARK:     if (key_ok)     state_nxt = last_round ? DONE : SUB;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= '0;
    end else begin
      unique case (state)
        IDLE:    if (ctrl.start)              round_q <= '0;
        INIT:    if (key_ok)                  round_q <= ROUND_W'(1);
        ARK:     if (key_ok && !last_round)   round_q <= round_q + ROUND_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl.busy       = (state != IDLE);
    ctrl.done       = 1'b0;
    ctrl.sub_en     = 1'b0;
    ctrl.state_ld   = 1'b0;
    ctrl.sel_init   = 1'b0;
    ctrl.mix_bypass = 1'b0;
    ctrl.key_req    = 1'b0;
    unique case (state)
      INIT: begin
        ctrl.sel_init = 1'b1;
        ctrl.key_req  = 1'b1;
        ctrl.state_ld = key_ok;
      end
      SUB:  ctrl.sub_en = 1'b1;
      ARK: begin
        ctrl.key_req    = 1'b1;
        ctrl.state_ld   = key_ok;
        ctrl.mix_bypass = last_round;
      end
      DONE: ctrl.done = 1'b1;
      default: ;
    endcase
  end

  assign ctrl.round = round_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl against a per-run expected-schedule model.
module tb_aes_round_ctrl;
  import aes_ctrl_pkg::*;

  localparam int NR  = AES_NR_128;
  localparam int SC  = SUBBYTES_LAT;
  localparam int LAT = 2 + NR * (SC + 1);
`ifdef AES_CTRL_KEY_WAIT_EN
  localparam bit KW = 1'b1;
`else
  localparam bit KW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NR(NR), .SUB_CYCLES(SC)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] round;
    logic       sub_en;
    logic       state_ld;
    logic       sel_init;
    logic       mix_bypass;
    logic       key_req;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    kp;   // key-dependent step (can stall)
  } ent_t;

  ent_t       q[$];
  logic [3:0] held;
  int         vec, err, cyc_no, start_cyc, done_cyc;
  int         n_done, n_ld, n_sub_rise, n_mix;
  logic       prev_sub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit b_sub, input bit b_ld, input bit b_init, input bit b_mix,
                      input bit b_key, input bit b_done, input int r, input bit kp);
    ent_t e;
    e.o            = '0;
    e.o.busy       = 1'b1;
    e.o.done       = b_done;
    e.o.round      = 4'(r);
    e.o.sub_en     = b_sub;
    e.o.state_ld   = b_ld;
    e.o.sel_init   = b_init;
    e.o.mix_bypass = b_mix;
    e.o.key_req    = b_key;
    e.kp           = kp;
    q.push_back(e);
  endtask

  // One block encryption as an ordered list of cycles.
  task automatic build_run();
    push(0, 1, 1, 0, 1, 0, 0, 1);
    for (int r = 1; r <= NR; r++) begin
      for (int s = 0; s < SC; s++) push(1, 0, 0, 0, 0, 0, r, 0);
      push(0, 1, 0, r == NR, 1, 0, r, 1);
    end
    push(0, 0, 0, 0, 0, 1, NR, 0);
  endtask

  task automatic clr_stats();
    n_done = 0; n_ld = 0; n_sub_rise = 0; n_mix = 0;
  endtask

  task automatic cyc(input bit st, input bit r, input bit kv);
    outs_t e, o;
    bit    stall;
    bus.start     = st;
    rst           = r;
    bus.key_valid = kv;
    @(negedge clk);
    stall = (q.size() != 0) && KW && q[0].kp && !kv;
    if (q.size() == 0) begin
      e       = '0;
      e.round = held;
    end else begin
      e = q[0].o;
      if (stall) e.state_ld = 1'b0;
    end
    o = {bus.busy, bus.done, bus.round, bus.sub_en, bus.state_ld,
         bus.sel_init, bus.mix_bypass, bus.key_req};
    chk($sformatf("outs@%0d", cyc_no), 32'(o), 32'(e));
    if (bus.done === 1'b1) begin n_done++; done_cyc = cyc_no; end
    if (bus.state_ld === 1'b1) n_ld++;
    if (bus.sub_en === 1'b1 && prev_sub !== 1'b1) n_sub_rise++;
    if (bus.mix_bypass === 1'b1) n_mix++;
    prev_sub = bus.sub_en;
    @(posedge clk);
    if (r) begin
      q.delete();
      held = '0;
    end else if (q.size() == 0) begin
      if (st) begin build_run(); start_cyc = cyc_no; end
    end else if (!stall) begin
      held = q[0].o.round;
      void'(q.pop_front());
    end
    cyc_no++;
    #1;
  endtask

  initial begin
    vec = 0; err = 0; cyc_no = 0; start_cyc = 0; done_cyc = 0;
    held = '0; prev_sub = 1'b0;
    clr_stats();
    rst = 1'b1; bus.start = 1'b0; bus.key_valid = 1'b1;
    @(posedge clk); #1;

    // reset dominates a held start
    repeat (3) cyc(1, 1, 1);

    // single run at defaults
    clr_stats();
    for (int k = 0; k < LAT + 3; k++) cyc(k == 0, 0, 1);
    chk("latency", 32'(done_cyc - start_cyc), 32'(LAT));
    chk("done_cnt", 32'(n_done), 32'd1);
    chk("sub_bursts", 32'(n_sub_rise), 32'(NR));
    chk("state_ld_cnt", 32'(n_ld), 32'(NR + 1));
    chk("mix_cnt", 32'(n_mix), 32'd1);

    // starts during busy and in DONE ignored, then back-to-back run
    clr_stats();
    for (int k = 0; k <= LAT; k++) cyc(k == 0 || k == 5 || k == 61 || k == LAT, 0, 1);
    chk("latency_busy_starts", 32'(done_cyc - start_cyc), 32'(LAT));
    for (int k = 0; k < LAT + 2; k++) cyc(k == 0, 0, 1);
    chk("latency_b2b", 32'(done_cyc - start_cyc), 32'(LAT));
    chk("done_cnt_b2b", 32'(n_done), 32'd2);

    // abort mid-run, then a clean run
    clr_stats();
    for (int k = 0; k <= 30; k++) cyc(k == 0, k == 30, 1);
    cyc(0, 0, 1);
    chk("abort_no_done", 32'(n_done), 32'd0);
    clr_stats();
    for (int k = 0; k < LAT + 2; k++) cyc(k == 0, 0, 1);
    chk("latency_after_abort", 32'(done_cyc - start_cyc), 32'(LAT));
    chk("done_cnt_after_abort", 32'(n_done), 32'd1);

`ifdef AES_CTRL_KEY_WAIT_EN
    // key stall in round-4 ARK
    clr_stats();
    for (int k = 0; k < LAT + 6; k++) cyc(k == 0, 0, !(k >= 25 && k <= 27));
    chk("latency_key_stall", 32'(done_cyc - start_cyc), 32'(LAT + 3));
    chk("state_ld_cnt_stall", 32'(n_ld), 32'(NR + 1));
`endif

    // randomized start/reset/key_valid traffic
    clr_stats();
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
